// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART blocks.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;

   localparam int DEBUG_DIV_DEFAULT = 5;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter; bit_end marks the last cycle of each bit.
module uart_bit_timer #(
   parameter int DIV_W = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   output logic             bit_end
);

   logic [DIV_W-1:0] cnt_q;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= div;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - DIV_W'(1);
      end
   end

   // Counter parks at zero, so bit_end also holds high while idle.
   assign bit_end = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter, LSB first, 1/2 stop bits, valid/ready input.
// Optional parity bit built only when UART_TX_PARITY_EN is defined.
//
//   state  | meaning
//   IDLE   | line high, ready for a word
//   START  | start bit (0)
//   DATA   | payload bits, LSB first
//   PARITY | parity bit (UART_TX_PARITY_EN builds only)
//   STOP   | one or two stop bits (1)
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int DIV_W     = 16,
   parameter int DEBUG_DIV = DEBUG_DIV_DEFAULT
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              debug_mode,
   input  logic [DIV_W-1:0]  baud_div,
   input  logic              stop2,
`ifdef UART_TX_PARITY_EN
   input  logic              par_en,
   input  logic              par_odd,
`endif
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx,
   output logic              tx_done,
   output logic              busy
);

   localparam int IDX_W = $clog2(DATA_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   uart_state_t       state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DIV_W-1:0]  sel_div, load_div;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              stop2_q, stop2_d;
   logic              second_q, second_d;
   logic              tx_q, tx_d;
   logic              load, bit_end, frame_end, accept;
`ifdef UART_TX_PARITY_EN
   logic              par_en_q, par_en_d;
   logic              par_odd_q, par_odd_d;
`endif

   uart_bit_timer #(.DIV_W(DIV_W)) u_timer (
      .Clk     (Clk),
      .Rst     (Rst),
      .load    (load),
      .div     (load_div),
      .bit_end (bit_end)
   );

   assign sel_div   = debug_mode ? DIV_W'(DEBUG_DIV) : baud_div;
   assign frame_end = !Rst && (state_q == STOP) && bit_end && (second_q || !stop2_q);
   assign tx_ready  = (state_q == IDLE) || frame_end;
   assign accept    = tx_valid && tx_ready;
   assign busy      = !tx_ready;
   assign tx_done   = frame_end;
   assign tx        = tx_q;

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      div_d    = div_q;
      idx_d    = idx_q;
      stop2_d  = stop2_q;
      second_d = second_q;
      load     = 1'b0;
      load_div = div_q;
`ifdef UART_TX_PARITY_EN
      par_en_d  = par_en_q;
      par_odd_d = par_odd_q;
`endif

      case (state_q)
         IDLE: ;
         START: begin
            if (bit_end) begin
               state_d = DATA;
               idx_d   = '0;
               load    = 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               load = 1'b1;
               if (idx_q == LAST_IDX) begin
                  second_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                  state_d = par_en_q ? PARITY : STOP;
`else
                  state_d = STOP;
`endif
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_d  = STOP;
               second_d = 1'b0;
               load     = 1'b1;
            end
         end
`endif
         STOP: begin
            if (frame_end) begin
               state_d = IDLE;
            end else if (bit_end) begin
               second_d = 1'b1;
               load     = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // An accept in the final stop cycle overrides the return to IDLE.
      if (accept) begin
         state_d  = START;
         data_d   = tx_data;
         div_d    = sel_div;
         stop2_d  = stop2;
         second_d = 1'b0;
         load     = 1'b1;
         load_div = sel_div;
`ifdef UART_TX_PARITY_EN
         par_en_d  = par_en;
         par_odd_d = par_odd;
`endif
      end

      case (state_d)
         START:   tx_d = START_BIT;
         DATA:    tx_d = data_q[idx_d];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = (^data_q) ^ par_odd_q;
`endif
         STOP:    tx_d = STOP_BIT;
         default: tx_d = IDLE_LVL;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q  <= IDLE;
         data_q   <= '0;
         div_q    <= '0;
         idx_q    <= '0;
         stop2_q  <= 1'b0;
         second_q <= 1'b0;
         tx_q     <= IDLE_LVL;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         div_q    <= div_d;
         idx_q    <= idx_d;
         stop2_q  <= stop2_d;
         second_q <= second_d;
         tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= par_en_d;
         par_odd_q <= par_odd_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed self-checking bench for uart_tx_param (DATA_W=8, DIV_W=16).
// Parity frames are exercised only when UART_TX_PARITY_EN is defined.
module tb_uart_tx_param;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        debug_mode;
   logic [15:0] baud_div;
   logic        stop2;
`ifdef UART_TX_PARITY_EN
   logic        par_en;
   logic        par_odd;
`endif
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx;
   logic        tx_done;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   uart_tx_param #(.DATA_W(8), .DIV_W(16), .DEBUG_DIV(5)) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .debug_mode (debug_mode),
      .baud_div   (baud_div),
      .stop2      (stop2),
`ifdef UART_TX_PARITY_EN
      .par_en     (par_en),
      .par_odd    (par_odd),
`endif
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx         (tx),
      .tx_done    (tx_done),
      .busy       (busy)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_tx"}, tx, 1'b1);
      chk({tag, "_ready"}, tx_ready, 1'b1);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, tx_done, 1'b0);
   endtask

   // Called in the accept cycle k (tx_ready high); returns in cycle k+F.
   // Inputs are scrambled during the frame to show they are latched at accept.
   task automatic send(input string tag, input logic [7:0] data, input int bd,
                       input logic dbg, input logic s2, input logic pe,
                       input logic po, input logic chain);
      logic [11:0] bitv;
      int d, nb, f, pos;
      d = dbg ? 5 : bd;
      bitv = '1;
      bitv[0] = 1'b0;
      for (int i = 0; i < 8; i++) bitv[1 + i] = data[i];
      pos = 9;
      if (pe) begin
         bitv[pos] = (^data) ^ po;
         pos++;
      end
      nb = pos + (s2 ? 2 : 1);
      f  = nb * (d + 1);

      tx_data    = data;
      baud_div   = 16'(bd);
      debug_mode = dbg;
      stop2      = s2;
`ifdef UART_TX_PARITY_EN
      par_en  = pe;
      par_odd = po;
`endif
      tx_valid = 1'b1;
      chk({tag, "_accept_ready"}, tx_ready, 1'b1);
      tick();

      baud_div   = 16'(bd + 2);
      debug_mode = ~dbg;
      stop2      = ~s2;
      tx_data    = ~data;
`ifdef UART_TX_PARITY_EN
      par_en  = ~pe;
      par_odd = ~po;
`endif
      tx_valid = chain;

      for (int j = 1; j <= f; j++) begin
         chk($sformatf("%s_tx_c%0d", tag, j), tx, bitv[(j - 1) / (d + 1)]);
         chk($sformatf("%s_ready_c%0d", tag, j), tx_ready, (j == f));
         chk($sformatf("%s_done_c%0d", tag, j), tx_done, (j == f));
         chk($sformatf("%s_busy_c%0d", tag, j), busy, (j != f));
         if (j < f) tick();
      end
   endtask

   initial begin
      Rst        = 1'b1;
      debug_mode = 1'b0;
      baud_div   = 16'd3;
      stop2      = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en  = 1'b0;
      par_odd = 1'b0;
`endif
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      tick();
      tick();
      chk_idle("reset");
      Rst = 1'b0;
      tick();
      chk_idle("post_reset");

      // 0xA5, div 3, one stop bit: 40-cycle frame
      send("a5_div3", 8'hA5, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_idle("a5_after");

      // back-to-back 0x00 then 0xFF with valid held
      send("b2b_first", 8'h00, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      send("b2b_second", 8'hFF, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_idle("b2b_after");

      // two stop bits, one cycle per bit: 11-cycle frame
      send("s2_div0", 8'h3C, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_idle("s2_after");

`ifdef UART_TX_PARITY_EN
      send("par_even", 8'hA5, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk_idle("par_even_after");
      send("par_odd", 8'hA5, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chk_idle("par_odd_after");
`endif

      // reset in cycle k+15 of a div-3 frame aborts it
      tx_data  = 8'h0F;
      baud_div = 16'd3;
      stop2    = 1'b0;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      for (int j = 1; j < 15; j++) tick();
      chk("abort_bit_before_rst", tx, 1'b1);
      chk("abort_busy_before_rst", busy, 1'b1);
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      chk_idle("abort_k16");
      for (int j = 0; j < 30; j++) begin
         chk($sformatf("abort_nodone_%0d", j), tx_done, 1'b0);
         chk($sformatf("abort_line_%0d", j), tx, 1'b1);
         tick();
      end
      send("after_abort_55", 8'h55, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_idle("after_abort_idle");

      // debug divisor overrides a large baud_div: 6-cycle bits
      send("debug_div", 8'h96, 433, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_idle("debug_after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
